// File: rtl/bp_me_pkg.sv
// Shared types for the ME DMA arbiter slice.
// Write FSM state encoding and perf counter width.
package bp_me_pkg;

  typedef enum logic {
    e_dma_arb_wr_idle,
    e_dma_arb_wr_data
  } bp_me_dma_arb_wr_state_e;

  localparam int dma_arb_perf_width_gp = 32;

endpackage

// File: rtl/bp_me_dma_arb_rr.sv
// Round-robin grant: first eligible requester at/after the pointer.
// Pointer moves past the winner only when the grant is taken.
module bp_me_dma_arb_rr
  import bp_me_pkg::*;
#(
  parameter int num_req_p = 4,
  localparam int id_w_lp = $clog2(num_req_p)
) (
  input  logic                 clk_i,
  input  logic                 reset_n_i,
  input  logic [num_req_p-1:0] elig_i,
  input  logic                 yumi_i,
  output logic [num_req_p-1:0] grant_oh_o,
  output logic [id_w_lp-1:0]   grant_id_o,
  output logic                 grant_v_o
);

  logic [id_w_lp-1:0] ptr_q, ptr_d;

  // Scan farthest-first so the closest eligible slot wins last.
  always_comb begin
    int idx;
    idx        = 0;
    grant_oh_o = '0;
    grant_id_o = '0;
    grant_v_o  = 1'b0;
    for (int k = num_req_p-1; k >= 0; k--) begin
      idx = int'(ptr_q) + k;
      if (idx >= num_req_p) idx = idx - num_req_p;
      if (elig_i[idx]) begin
        grant_oh_o      = '0;
        grant_oh_o[idx] = 1'b1;
        grant_id_o      = id_w_lp'(idx);
        grant_v_o       = 1'b1;
      end
    end
  end

  always_comb begin
    ptr_d = ptr_q;
    if (yumi_i) begin
      if (int'(grant_id_o) == num_req_p-1) ptr_d = '0;
      else ptr_d = grant_id_o + id_w_lp'(1);
    end
  end

  always_ff @(posedge clk_i or negedge reset_n_i) begin
    if (!reset_n_i) ptr_q <= '0;
    else ptr_q <= ptr_d;
  end

endmodule

// File: rtl/bp_me_dma_arbiter.sv
// Shares one L2 DMA channel among requesters; write lock per burst,
// in-order read routing via tag FIFO. Optional BP_ME_DMA_ARB_PERF_EN.
module bp_me_dma_arbiter
  import bp_me_pkg::*;
#(
  parameter int num_req_p       = 4,
  parameter int dma_pkt_width_p = 48,
  parameter int data_width_p    = 64,
  parameter int burst_len_p     = 8,
  parameter int tag_els_p       = 4,
  localparam int id_w_lp = $clog2(num_req_p),
  localparam int pw_lp   = dma_pkt_width_p,
  localparam int dw_lp   = data_width_p
) (
  input  logic                           clk_i,
  input  logic                           reset_n_i,
  input  logic [num_req_p*pw_lp-1:0]     req_pkt_i,
  input  logic [num_req_p-1:0]           req_pkt_v_i,
  output logic [num_req_p-1:0]           req_pkt_ready_and_o,
  input  logic [num_req_p*dw_lp-1:0]     req_data_i,
  input  logic [num_req_p-1:0]           req_data_v_i,
  output logic [num_req_p-1:0]           req_data_ready_and_o,
  output logic [num_req_p*dw_lp-1:0]     req_data_o,
  output logic [num_req_p-1:0]           req_data_v_o,
  input  logic [num_req_p-1:0]           req_data_ready_and_i,
  output logic [pw_lp-1:0]               mem_pkt_o,
  output logic                           mem_pkt_v_o,
  input  logic                           mem_pkt_ready_and_i,
  output logic [dw_lp-1:0]               mem_data_o,
  output logic                           mem_data_v_o,
  input  logic                           mem_data_ready_and_i,
  input  logic [dw_lp-1:0]               mem_data_i,
  input  logic                           mem_data_v_i,
  output logic                           mem_data_ready_and_o,
  output logic [num_req_p*dma_arb_perf_width_gp-1:0] perf_grant_o
);

  localparam int cnt_w_lp = (burst_len_p > 1) ? $clog2(burst_len_p) : 1;
  localparam int tp_w_lp  = (tag_els_p > 1) ? $clog2(tag_els_p) : 1;
  localparam int tc_w_lp  = $clog2(tag_els_p+1);
  localparam logic [cnt_w_lp-1:0] last_lp = cnt_w_lp'(burst_len_p-1);

  bp_me_dma_arb_wr_state_e wr_state_q;
  logic [id_w_lp-1:0]  owner_q;
  logic [cnt_w_lp-1:0] wcnt_q, rcnt_q;
  logic [id_w_lp-1:0]  tag_mem_q [tag_els_p];
  logic [tp_w_lp-1:0]  tag_wptr_q, tag_rptr_q;
  logic [tc_w_lp-1:0]  tag_cnt_q, tag_cnt_d;

  logic [num_req_p-1:0] elig, grant_oh;
  logic [id_w_lp-1:0]   grant_id, tag_head;
  logic grant_v, pkt_hs, pkt_wr, wr_busy, wr_beat;
  logic tag_full, tag_empty, rd_beat, push, pop;

  assign wr_busy   = (wr_state_q == e_dma_arb_wr_data);
  assign tag_full  = (tag_cnt_q == tc_w_lp'(tag_els_p));
  assign tag_empty = (tag_cnt_q == '0);
  assign tag_head  = tag_mem_q[tag_rptr_q];

  // Reset gate keeps pkt valid low while requesters still assert valid.
  always_comb begin
    elig = '0;
    for (int i = 0; i < num_req_p; i++) begin
      elig[i] = reset_n_i & req_pkt_v_i[i]
              & (req_pkt_i[i*pw_lp+pw_lp-1] ? !wr_busy : !tag_full);
    end
  end

  bp_me_dma_arb_rr #(.num_req_p(num_req_p)) rr (
    .clk_i      (clk_i),
    .reset_n_i  (reset_n_i),
    .elig_i     (elig),
    .yumi_i     (pkt_hs),
    .grant_oh_o (grant_oh),
    .grant_id_o (grant_id),
    .grant_v_o  (grant_v)
  );

  assign mem_pkt_v_o = grant_v;
  assign mem_pkt_o   = req_pkt_i[int'(grant_id)*pw_lp +: pw_lp];
  assign pkt_hs      = grant_v & mem_pkt_ready_and_i;
  assign pkt_wr      = mem_pkt_o[pw_lp-1];
  assign req_pkt_ready_and_o = grant_oh & {num_req_p{mem_pkt_ready_and_i}};

  assign mem_data_o   = req_data_i[int'(owner_q)*dw_lp +: dw_lp];
  assign mem_data_v_o = wr_busy & req_data_v_i[owner_q];
  assign wr_beat      = mem_data_v_o & mem_data_ready_and_i;
  assign req_data_ready_and_o = wr_busy
    ? (num_req_p'(mem_data_ready_and_i) << owner_q) : '0;

  always_ff @(posedge clk_i or negedge reset_n_i) begin
    if (!reset_n_i) begin
      wr_state_q <= e_dma_arb_wr_idle;
      owner_q    <= '0;
      wcnt_q     <= '0;
    end else begin
      unique case (wr_state_q)
        e_dma_arb_wr_idle: begin
          if (pkt_hs & pkt_wr) begin
            wr_state_q <= e_dma_arb_wr_data;
            owner_q    <= grant_id;
            wcnt_q     <= '0;
          end
        end
        e_dma_arb_wr_data: begin
          if (wr_beat) begin
            if (wcnt_q == last_lp) begin
              wr_state_q <= e_dma_arb_wr_idle;
              wcnt_q     <= '0;
            end else begin
              wcnt_q <= wcnt_q + cnt_w_lp'(1);
            end
          end
        end
        default: wr_state_q <= e_dma_arb_wr_idle;
      endcase
    end
  end

  assign req_data_o = {num_req_p{mem_data_i}};
  assign mem_data_ready_and_o = !tag_empty & req_data_ready_and_i[tag_head];
  assign req_data_v_o = (mem_data_v_i & !tag_empty)
    ? (num_req_p'(1) << tag_head) : '0;
  assign rd_beat = mem_data_v_i & mem_data_ready_and_o;
  assign push    = pkt_hs & !pkt_wr;
  assign pop     = rd_beat & (rcnt_q == last_lp);
  assign tag_cnt_d = tag_cnt_q + tc_w_lp'(push) - tc_w_lp'(pop);

  always_ff @(posedge clk_i or negedge reset_n_i) begin
    if (!reset_n_i) begin
      tag_wptr_q <= '0;
      tag_rptr_q <= '0;
      tag_cnt_q  <= '0;
      rcnt_q     <= '0;
      for (int i = 0; i < tag_els_p; i++) tag_mem_q[i] <= '0;
    end else begin
      tag_cnt_q <= tag_cnt_d;
      if (push) begin
        tag_mem_q[tag_wptr_q] <= grant_id;
        tag_wptr_q <= (tag_wptr_q == tp_w_lp'(tag_els_p-1))
          ? '0 : tag_wptr_q + tp_w_lp'(1);
      end
      if (rd_beat) rcnt_q <= pop ? '0 : rcnt_q + cnt_w_lp'(1);
      if (pop) begin
        tag_rptr_q <= (tag_rptr_q == tp_w_lp'(tag_els_p-1))
          ? '0 : tag_rptr_q + tp_w_lp'(1);
      end
    end
  end

  // Memory must never return data that no read is waiting for.
  assert property (@(posedge clk_i) disable iff (!reset_n_i)
    mem_data_v_i |-> !tag_empty);

`ifdef BP_ME_DMA_ARB_PERF_EN
  logic [dma_arb_perf_width_gp-1:0] perf_q [num_req_p];

  always_ff @(posedge clk_i or negedge reset_n_i) begin
    if (!reset_n_i) begin
      for (int i = 0; i < num_req_p; i++) perf_q[i] <= '0;
    end else begin
      for (int i = 0; i < num_req_p; i++) begin
        if (pkt_hs & grant_oh[i] & ~&perf_q[i])
          perf_q[i] <= perf_q[i] + dma_arb_perf_width_gp'(1);
      end
    end
  end

  always_comb begin
    perf_grant_o = '0;
    for (int i = 0; i < num_req_p; i++)
      perf_grant_o[i*dma_arb_perf_width_gp +: dma_arb_perf_width_gp]
        = perf_q[i];
  end
`else
  assign perf_grant_o = '0;
`endif

endmodule
